// File: rtl/buzzer_sos_seq_module.sv
// SOS Morse sequencer for a buzzer: ... --- ... (dot = 1 unit, dash = 3 units).
// Optional macro BUZZER_TONE_EN selects a passive-buzzer square-wave tone instead of a steady level.
module buzzer_sos_seq_module #(
   parameter logic [27:0] T_UNIT    = 28'd4_999_999,
   parameter logic [15:0] TONE_HALF = 16'd12_499
) (
   input  logic CLK,
   input  logic RST,
   input  logic SOS_En_Sig,
   input  logic Stop_Sig,
   output logic Pin_Out,
   output logic Busy,
   output logic Done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [3:0]  r_sym;
   logic [3:0]  w_symNext;
   logic [3:0]  w_symInc;
   logic [27:0] r_unitCnt;
   logic [27:0] w_unitCntNext;
   logic [1:0]  r_unitsLeft;
   logic [1:0]  w_unitsLeftNext;
   logic        r_busy;
   logic        w_busyNext;
   logic        r_done;
   logic        w_doneNext;
   logic        r_pinOut;
   logic        w_pinOutNext;
   logic        w_unitEnd;
   logic        w_isDash;
   logic        w_longGap;
`ifdef BUZZER_TONE_EN
   logic [15:0] r_toneCnt;
   logic [15:0] w_toneCntNext;
`endif

   assign w_unitEnd = (r_unitCnt == T_UNIT);
   assign w_symInc  = r_sym + 4'd1;
   // units-remaining holds "extra units after the current one": 2 for dashes and long gaps
   assign w_isDash  = (w_symInc >= 4'd3) && (w_symInc <= 4'd5);
   assign w_longGap = (r_sym == 4'd2) || (r_sym == 4'd5);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_sym       <= 4'd0;
         r_unitCnt   <= 28'd0;
         r_unitsLeft <= 2'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pinOut    <= 1'b0;
`ifdef BUZZER_TONE_EN
         r_toneCnt   <= 16'd0;
`endif
      end else begin
         r_state     <= w_stateNext;
         r_sym       <= w_symNext;
         r_unitCnt   <= w_unitCntNext;
         r_unitsLeft <= w_unitsLeftNext;
         r_busy      <= w_busyNext;
         r_done      <= w_doneNext;
         r_pinOut    <= w_pinOutNext;
`ifdef BUZZER_TONE_EN
         r_toneCnt   <= w_toneCntNext;
`endif
      end
   end

   always_comb begin
      w_stateNext     = r_state;
      w_symNext       = r_sym;
      w_unitCntNext   = r_unitCnt;
      w_unitsLeftNext = r_unitsLeft;
      w_busyNext      = r_busy;
      w_doneNext      = 1'b0;

      if (Stop_Sig) begin
         w_stateNext     = IDLE;
         w_symNext       = 4'd0;
         w_unitCntNext   = 28'd0;
         w_unitsLeftNext = 2'd0;
         w_busyNext      = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (SOS_En_Sig) begin
                  w_stateNext     = ON;
                  w_symNext       = 4'd0;
                  w_unitCntNext   = 28'd0;
                  w_unitsLeftNext = 2'd0;
                  w_busyNext      = 1'b1;
               end
            end
            ON: begin
               if (!w_unitEnd) begin
                  w_unitCntNext = r_unitCnt + 28'd1;
               end else begin
                  w_unitCntNext = 28'd0;
                  if (r_unitsLeft != 2'd0) begin
                     w_unitsLeftNext = r_unitsLeft - 2'd1;
                  end else if (r_sym == 4'd8) begin
                     w_stateNext = IDLE;
                     w_symNext   = 4'd0;
                     w_busyNext  = 1'b0;
                     w_doneNext  = 1'b1;
                  end else begin
                     w_stateNext     = GAP;
                     w_unitsLeftNext = w_longGap ? 2'd2 : 2'd0;
                  end
               end
            end
            GAP: begin
               if (!w_unitEnd) begin
                  w_unitCntNext = r_unitCnt + 28'd1;
               end else begin
                  w_unitCntNext = 28'd0;
                  if (r_unitsLeft != 2'd0) begin
                     w_unitsLeftNext = r_unitsLeft - 2'd1;
                  end else begin
                     w_stateNext     = ON;
                     w_symNext       = w_symInc;
                     w_unitsLeftNext = w_isDash ? 2'd2 : 2'd0;
                  end
               end
            end
            default: begin
               w_stateNext     = IDLE;
               w_symNext       = 4'd0;
               w_unitCntNext   = 28'd0;
               w_unitsLeftNext = 2'd0;
               w_busyNext      = 1'b0;
            end
         endcase
      end
   end

`ifdef BUZZER_TONE_EN
   // Tone phase restarts low on every ON entry, so each symbol begins identically.
   always_comb begin
      w_toneCntNext = 16'd0;
      w_pinOutNext  = 1'b0;
      if ((w_stateNext == ON) && (r_state == ON)) begin
         if (r_toneCnt == TONE_HALF) begin
            w_pinOutNext = ~r_pinOut;
         end else begin
            w_toneCntNext = r_toneCnt + 16'd1;
            w_pinOutNext  = r_pinOut;
         end
      end
   end
`else
   always_comb begin
      w_pinOutNext = (w_stateNext == ON);
   end
`endif

   assign Pin_Out = r_pinOut;
   assign Busy    = r_busy;
   assign Done    = r_done;

endmodule

// File: tb/tb_buzzer_sos_seq_module.sv
// Randomized testbench for buzzer_sos_seq_module; expected outputs come from a
// cycle-position model indexing a precomputed SOS waveform table.
module tb_buzzer_sos_seq_module;

   localparam logic [27:0] T_UNIT    = 28'd3;
   localparam logic [15:0] TONE_HALF = 16'd1;
   localparam int UNIT    = 4;
   localparam int HALF    = 2;
   localparam int PAT_LEN = 27 * UNIT;

   logic CLK = 1'b0;
   logic RST;
   logic SOS_En_Sig;
   logic Stop_Sig;
   logic Pin_Out;
   logic Busy;
   logic Done;

   int   wave [PAT_LEN];
   int   modelPos = -1;
   logic expPin = 1'b0;
   logic expBusy = 1'b0;
   logic expDone = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   int   busyCount;
   int   doneCount;

   buzzer_sos_seq_module #(
      .T_UNIT   (T_UNIT),
      .TONE_HALF(TONE_HALF)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .SOS_En_Sig(SOS_En_Sig),
      .Stop_Sig  (Stop_Sig),
      .Pin_Out   (Pin_Out),
      .Busy      (Busy),
      .Done      (Done)
   );

   always #5 CLK = ~CLK;

   // Expected SOS waveform: on-times in units, separated by gaps in units.
   task automatic buildWave();
      int idx;
      int onUnits;
      int gapUnits;
      idx = 0;
      for (int s = 0; s < 9; s++) begin
         onUnits = (s >= 3 && s <= 5) ? 3 : 1;
         for (int c = 0; c < onUnits * UNIT; c++) begin
`ifdef BUZZER_TONE_EN
            wave[idx] = (c / HALF) % 2;
`else
            wave[idx] = 1;
`endif
            idx++;
         end
         if (s < 8) begin
            gapUnits = (s == 2 || s == 5) ? 3 : 1;
            for (int c = 0; c < gapUnits * UNIT; c++) begin
               wave[idx] = 0;
               idx++;
            end
         end
      end
   endtask

   task automatic modelStep(input logic rst, input logic sos, input logic stop);
      expDone = 1'b0;
      if (rst || stop) begin
         modelPos = -1;
      end else if (modelPos < 0) begin
         if (sos) modelPos = 0;
      end else begin
         modelPos++;
         if (modelPos == PAT_LEN) begin
            modelPos = -1;
            expDone  = 1'b1;
         end
      end
      expBusy = (modelPos >= 0);
      expPin  = (modelPos >= 0) ? wave[modelPos][0] : 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      compared++;
      assert (Pin_Out === expPin) else begin
         mismatched++;
         $error("[TB] FAIL %s Pin_Out observed=%b expected=%b t=%0t", tag, Pin_Out, expPin, $time);
      end
      compared++;
      assert (Busy === expBusy) else begin
         mismatched++;
         $error("[TB] FAIL %s Busy observed=%b expected=%b t=%0t", tag, Busy, expBusy, $time);
      end
      compared++;
      assert (Done === expDone) else begin
         mismatched++;
         $error("[TB] FAIL %s Done observed=%b expected=%b t=%0t", tag, Done, expDone, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic sos, input logic stop, input string tag);
      RST        = rst;
      SOS_En_Sig = sos;
      Stop_Sig   = stop;
      @(posedge CLK);
      #1;
      modelStep(rst, sos, stop);
      checkOutput(tag);
      if (Busy === 1'b1) busyCount++;
      if (Done === 1'b1) doneCount++;
   endtask

   initial begin
      RST        = 1'b1;
      SOS_En_Sig = 1'b0;
      Stop_Sig   = 1'b0;
      buildWave();

      $display("[TB] reset and idle");
      applyStimulus(1'b1, 1'b0, 1'b0, "reset");
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, "idle");

      $display("[TB] single pattern");
      busyCount = 0;
      doneCount = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, "start");
      for (int i = 0; i < 115; i++) applyStimulus(1'b0, 1'b0, 1'b0, "pattern");
      compared++;
      assert (busyCount === PAT_LEN) else begin
         mismatched++;
         $error("[TB] FAIL busy_len observed=%0d expected=%0d", busyCount, PAT_LEN);
      end
      compared++;
      assert (doneCount === 1) else begin
         mismatched++;
         $error("[TB] FAIL done_count observed=%0d expected=1", doneCount);
      end

      $display("[TB] restart attempts while busy");
      doneCount = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, "start2");
      for (int i = 1; i < 115; i++)
         applyStimulus(1'b0, 1'((i == 50) || ($urandom_range(0, 9) == 0 && i < 107)), 1'b0, "ignore_sos");
      compared++;
      assert (doneCount === 1) else begin
         mismatched++;
         $error("[TB] FAIL done_once observed=%0d expected=1", doneCount);
      end

      $display("[TB] stop mid pattern");
      doneCount = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, "start3");
      for (int i = 1; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b0, "pre_stop");
      applyStimulus(1'b0, 1'b0, 1'b1, "stop");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, "post_stop");
      compared++;
      assert (doneCount === 0) else begin
         mismatched++;
         $error("[TB] FAIL stop_no_done observed=%0d expected=0", doneCount);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, "restart");
      for (int i = 0; i < 112; i++) applyStimulus(1'b0, 1'b0, 1'b0, "full_after_stop");

      $display("[TB] stop and start together, reset mid pattern");
      applyStimulus(1'b0, 1'b1, 1'b1, "stop_wins");
      applyStimulus(1'b0, 1'b0, 1'b0, "stop_wins_idle");
      doneCount = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, "start4");
      for (int i = 1; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, "pre_rst");
      applyStimulus(1'b1, 1'b1, 1'b0, "mid_reset");
      applyStimulus(1'b0, 1'b1, 1'b0, "first_after_rst");
      for (int i = 0; i < 110; i++) applyStimulus(1'b0, 1'b0, 1'b0, "after_rst");
      compared++;
      assert (doneCount === 1) else begin
         mismatched++;
         $error("[TB] FAIL rst_done observed=%0d expected=1", doneCount);
      end

      $display("[TB] random traffic");
      for (int i = 0; i < 800; i++)
         applyStimulus(1'($urandom_range(0, 399) == 0),
                       1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 199) == 0), "random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/buzzer_sos_seq_module.md
BUZZER_SOS_SEQ_MODULE -- requirements
Module: buzzer_sos_seq_module

Interface
REQ-001 Parameter T_UNIT, default 28'd4_999_999, Morse unit length minus one in CLK cycles (100 ms at 50 MHz).
REQ-002 Parameter TONE_HALF, default 16'd12_499, tone half-period minus one in CLK cycles (2 kHz at 50 MHz).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 SOS_En_Sig  input  1  start request, one-cycle pulse from the periodic enable source.
REQ-006 Stop_Sig  input  1  synchronous abort of the current pattern.
REQ-007 Pin_Out  output  1  buzzer drive, registered.
REQ-008 Busy  output  1  high while a pattern is in progress, registered.
REQ-009 Done  output  1  one-cycle pulse on normal pattern completion, registered.

Function
REQ-010 FSM states: IDLE, ON, GAP; symbol index sym 0..8; unit counter 28 bits; units-remaining counter 2 bits.
REQ-011 IDLE with SOS_En_Sig=1 and Stop_Sig=0 -> ON, sym=0; Busy=1 from the next cycle.
REQ-012 SOS_En_Sig while Busy=1 is ignored; no queuing, no restart.
REQ-013 Symbol on-time: sym 0-2 and 6-8 = 1 unit (dot); sym 3-5 = 3 units (dash); one unit = T_UNIT+1 cycles.
REQ-014 ON ends -> GAP if sym<8; gap = 3 units after sym 2 and 5, 1 unit otherwise.
REQ-015 GAP ends -> ON with sym+1.
REQ-016 ON ends with sym=8 -> IDLE; in that cycle Busy=0 and Done=1 for exactly one cycle.
REQ-017 Total pattern: 15 units Pin_Out-active, 12 units gap, Busy high exactly 27*(T_UNIT+1) cycles.
REQ-018 Pin_Out=0 in IDLE and GAP; in ON, behaviour per REQ-025/026.
REQ-019 Stop_Sig=1 in any state -> IDLE next cycle; Pin_Out=0, Busy=0, Done=0; counters cleared.
REQ-020 Stop_Sig and SOS_En_Sig both high in IDLE: Stop wins, no start.
REQ-021 Unit counter counts 0..T_UNIT and wraps to 0; it never exceeds T_UNIT.

Reset
REQ-022 RST=1 at a rising edge -> state IDLE, sym=0, all counters 0, Pin_Out=0, Busy=0, Done=0.
REQ-023 RST has priority over Stop_Sig and SOS_En_Sig; reset mid-pattern aborts without Done.
REQ-024 First start is accepted in the first cycle after RST deasserts.

Configuration
REQ-025 Macro BUZZER_TONE_EN defined: in ON, Pin_Out toggles every TONE_HALF+1 cycles (passive buzzer); tone counter and Pin_Out phase restart at 0 (low) on each ON entry.
REQ-026 Macro BUZZER_TONE_EN undefined: Pin_Out=1 for the whole ON state (active buzzer); no tone counter is synthesized.

Verification (T_UNIT=3, TONE_HALF=1)
REQ-027 RST held 2 cycles, then idle 10 cycles -> Pin_Out=0, Busy=0, Done=0 throughout.
REQ-028 Single SOS_En_Sig pulse, tone disabled -> Pin_Out high runs of 4,4,4,12,12,12,4,4,4 cycles separated by low runs of 4,4,12,4,4,12,4,4; Busy high 108 cycles; Done high 1 cycle as Busy falls.
REQ-029 Tone enabled, same stimulus -> in each ON period Pin_Out is low 2 cycles, high 2 cycles, repeating; in GAP Pin_Out=0.
REQ-030 Second SOS_En_Sig pulse at cycle 50 of a pattern -> waveform identical to REQ-028; exactly one Done.
REQ-031 Stop_Sig pulse at cycle 30 -> Pin_Out=0, Busy=0 next cycle, no Done; new start afterwards yields full REQ-028 waveform.
REQ-032 SOS_En_Sig and Stop_Sig together in IDLE -> Busy stays 0; RST asserted at cycle 20 of a pattern -> all outputs 0 next cycle, no Done.
